alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 Parameter: SEL_W, 4, ALU operation-select width; codes from alu_op.vh, passed through unchanged.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-008 req0_sel  input  SEL_W  requester 0 ALU op.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as REQ-005..008 for requester 1.
REQ-010 alu_a, alu_b  output  WIDTH  operands to shared combinational alu.
REQ-011 alu_sel  output  SEL_W  op select to shared alu.
REQ-012 alu_out  input  WIDTH  result from shared alu.
REQ-013 rsp_valid  output  1  result held for owning requester.
REQ-014 rsp_id  output  1  owning requester of result (0/1).
REQ-015 rsp_data  output  WIDTH  registered ALU result.
REQ-016 rsp_ready  input  1  owner consumes result.

Function
REQ-017 FSM states IDLE, EXEC, RESP; encoding free.
REQ-018 IDLE: reqN_ready asserted combinationally only for arbitration winner among valid requesters; never both; both 0 if none valid.
REQ-019 Handshake fires on reqN_valid & reqN_ready; a, b, sel, id latched into internal registers; IDLE -> EXEC.
REQ-020 EXEC (exactly 1 cycle): alu_a/alu_b/alu_sel driven from latched registers; alu_out captured into rsp_data, rsp_id set; EXEC -> RESP.
REQ-021 Outside EXEC, alu_a/alu_b/alu_sel hold latched values (no glitching from live request inputs).
REQ-022 RESP: rsp_valid=1, rsp_data/rsp_id stable until rsp_valid & rsp_ready; then RESP -> IDLE, rsp_valid=0 next cycle.
REQ-023 Latency: accept at cycle N -> rsp_valid at N+2; minimum issue interval 3 cycles; no request accepted in EXEC or RESP.
REQ-024 Round-robin: pointer names preferred requester; both valid -> preferred wins; on each accept pointer := other requester.
REQ-025 Single valid requester always wins regardless of pointer.
REQ-026 Arithmetic/width: block never modifies operands or result; overflow wrap is the alu's behaviour, passed through bit-exact.
REQ-027 Requester may drop valid before ready without side effect; inputs after acceptance ignored.

Reset
REQ-028 rst asserted any time, including mid-EXEC/RESP: state -> IDLE immediately, pending op and result discarded.
REQ-029 Reset values: req0_ready=0, req1_ready=0 (until first cycle after release), rsp_valid=0, rsp_id=0, rsp_data=0, alu_a=0, alu_b=0, alu_sel=0, pointer=0 (requester 0 preferred).

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both valid, pointer logic absent.
REQ-031 Macro undefined: round-robin per REQ-024.

Verification
REQ-032 req0 only, a=10, b=5, sel=`ADD, rsp_ready=1 -> req0_ready at N, rsp_valid at N+2, rsp_id=0, rsp_data=15, IDLE at N+3.
REQ-033 Both valid from reset, req0 `ADD 7FFFFFFF+1, req1 `SUB 2032-32 -> req0 first (rsp_data=80000000, id 0), then req1 (rsp_data=2000, id 1).
REQ-034 Both held valid for 4 transactions (round-robin build) -> grant order 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-035 RESP with rsp_ready=0 for 5 cycles, req1 valid -> rsp_valid/rsp_data/rsp_id stable, req1_ready=0 throughout, req1 accepted cycle after consume.
REQ-036 rst asserted during EXEC -> rsp_valid never rises, all outputs at REQ-029 values same cycle, next accepted request uses pointer=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester channels, the shared-ALU
// operand/result path and the response channel of alu_arbiter.
// Ports (signals): req0_*/req1_* {valid, ready, a, b, sel},
//   alu_a, alu_b, alu_sel, alu_out, rsp_valid, rsp_id, rsp_data, rsp_ready.
// Modports: master = arbiter side, slave = requester/ALU/consumer side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [SEL_W-1:0] req0_sel;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [SEL_W-1:0] req1_sel;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_out;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ready;

    modport master (
        input  req0_valid, req0_a, req0_b, req0_sel,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );

    modport slave (
        output req0_valid, req0_a, req0_b, req0_sel,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// One operation in flight: IDLE (arbitrate) -> EXEC (1 cycle) -> RESP.
// Ports: clk, rst (async, active-high), bus (alu_arbiter_if.master).
// Build option: ALU_ARB_FIXED_PRIO_EN -> requester 0 always wins ties,
//   otherwise ties are broken round-robin.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [SEL_W-1:0] sel_q;
    logic             id_q;
    logic [WIDTH-1:0] data_q;
    logic             rsp_id_q;
    logic             grant0;
    logic             grant1;
    logic             fire;
    logic             tie_pick1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign tie_pick1 = 1'b0;
`else
    // ptr_q names the requester preferred on a tie.
    logic ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (fire) begin
            ptr_q <= ~grant1;
        end
    end

    assign tie_pick1 = ptr_q;
`endif

    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // Ready is withheld while reset is held.
                if (!rst) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        grant1 = tie_pick1;
                        grant0 = ~tie_pick1;
                    end else begin
                        grant0 = bus.req0_valid;
                        grant1 = bus.req1_valid;
                    end
                end
                if (grant0 || grant1) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fire = grant0 | grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            id_q     <= 1'b0;
            data_q   <= '0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                a_q   <= grant1 ? bus.req1_a : bus.req0_a;
                b_q   <= grant1 ? bus.req1_b : bus.req0_b;
                sel_q <= grant1 ? bus.req1_sel : bus.req0_sel;
                id_q  <= grant1;
            end
            if (state_q == EXEC) begin
                data_q   <= bus.alu_out;
                rsp_id_q <= id_q;
            end
        end
    end

    // ALU inputs come only from the latched copy, never live requests.
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_sel    = sel_q;

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table, multi-cycle corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_arbiter_if #(.WIDTH(32), .SEL_W(4)) bus ();

    alu_arbiter #(.WIDTH(32), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] alu_fn(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [3:0]  s
    );
        case (s)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return {a[15:0], b[15:0]};
        endcase
    endfunction

    assign bus.alu_out = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req0_sel = '0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0;
        bus.req1_sel = '0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  s0;
        logic        v1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  s1;
        logic        r0;
        logic        r1;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[5];

    // Reference model state (transaction level).
    bit          m_pend;
    int          m_acc;
    bit          m_id;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_s;
    logic [31:0] m_d;
    int          m_pref;

    initial begin
        int grants[$];
        bit both_seen;
        checks = 0;
        errors = 0;
        idle_inputs();

        vecs[0] = '{1, 32'd10, 32'd5, OP_ADD, 0, 0, 0, OP_ADD,
                    1, 0, 32'd15};
        vecs[1] = '{0, 0, 0, OP_ADD, 1, 32'd2032, 32'd32, OP_SUB,
                    0, 1, 32'd2000};
        vecs[2] = '{1, 32'h7fffffff, 32'd1, OP_ADD,
                    1, 32'd2032, 32'd32, OP_SUB,
                    1, 0, 32'h80000000};
        vecs[3] = '{1, 32'hff00ff00, 32'h0f0f0f0f, OP_AND,
                    0, 0, 0, OP_ADD, 1, 0, 32'h0f000f00};
        vecs[4] = '{0, 0, 0, OP_ADD,
                    1, 32'hffffffff, 32'h12345678, OP_XOR,
                    0, 1, 32'hedcba987};

        // Reset values while rst held, with both requesters valid.
        rst = 1'b1;
        bus.req0_valid = 1; bus.req1_valid = 1;
        tick();
        @(negedge clk);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_sel", bus.alu_sel, 0);

        // Directed vector table: single transaction from reset.
        foreach (vecs[i]) begin
            do_reset();
            bus.req0_valid = vecs[i].v0; bus.req0_a = vecs[i].a0;
            bus.req0_b = vecs[i].b0; bus.req0_sel = vecs[i].s0;
            bus.req1_valid = vecs[i].v1; bus.req1_a = vecs[i].a1;
            bus.req1_b = vecs[i].b1; bus.req1_sel = vecs[i].s1;
            @(negedge clk);
            check("vec_ready0", bus.req0_ready, vecs[i].r0);
            check("vec_ready1", bus.req1_ready, vecs[i].r1);
            tick();
            bus.req0_valid = 0; bus.req1_valid = 0;
            bus.req0_a = 32'hdeadbeef; bus.req1_a = 32'hdeadbeef;
            @(negedge clk);
            check("vec_exec_rsp_valid", bus.rsp_valid, 0);
            check("vec_exec_alu_a", bus.alu_a,
                  vecs[i].r1 ? vecs[i].a1 : vecs[i].a0);
            tick();
            @(negedge clk);
            check("vec_rsp_valid", bus.rsp_valid, 1);
            check("vec_rsp_id", bus.rsp_id, vecs[i].r1);
            check("vec_rsp_data", bus.rsp_data, vecs[i].data);
            tick();
            @(negedge clk);
            check("vec_idle_rsp_valid", bus.rsp_valid, 0);
        end

        // Both valid from reset: req0 first, then req1.
        do_reset();
        bus.req0_valid = 1; bus.req0_a = 32'h7fffffff;
        bus.req0_b = 32'd1; bus.req0_sel = OP_ADD;
        bus.req1_valid = 1; bus.req1_a = 32'd2032;
        bus.req1_b = 32'd32; bus.req1_sel = OP_SUB;
        @(negedge clk);
        check("both_first_r0", bus.req0_ready, 1);
        check("both_first_r1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 0;
        @(negedge clk);
        check("both_exec_r1", bus.req1_ready, 0);
        tick();
        @(negedge clk);
        check("both_rsp0_data", bus.rsp_data, 32'h80000000);
        check("both_rsp0_id", bus.rsp_id, 0);
        tick();
        @(negedge clk);
        check("both_second_r1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 0;
        tick();
        @(negedge clk);
        check("both_rsp1_data", bus.rsp_data, 32'd2000);
        check("both_rsp1_id", bus.rsp_id, 1);
        check("both_rsp1_valid", bus.rsp_valid, 1);
        tick();

        // Both held valid: grant order over 4 transactions.
        do_reset();
        bus.req0_valid = 1; bus.req1_valid = 1;
        both_seen = 0;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) both_seen = 1;
            if (bus.req0_ready) grants.push_back(0);
            else if (bus.req1_ready) grants.push_back(1);
            tick();
        end
        check("rr_never_both", both_seen, 0);
        check("rr_count", grants.size(), 4);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            check("rr_order", k < grants.size() ? grants[k] : -1, 0);
`else
            check("rr_order", k < grants.size() ? grants[k] : -1, k % 2);
`endif
        end
        idle_inputs();
        repeat (4) tick();

        // Stalled response with req1 waiting.
        do_reset();
        bus.rsp_ready = 0;
        bus.req0_valid = 1; bus.req0_a = 3; bus.req0_b = 4;
        bus.req0_sel = OP_ADD;
        @(negedge clk);
        check("stall_accept_r0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_a = 100; bus.req1_b = 1;
        bus.req1_sel = OP_SUB;
        @(negedge clk);
        check("stall_exec_r1", bus.req1_ready, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_rsp_valid", bus.rsp_valid, 1);
            check("stall_rsp_data", bus.rsp_data, 7);
            check("stall_rsp_id", bus.rsp_id, 0);
            check("stall_r1", bus.req1_ready, 0);
            tick();
        end
        bus.rsp_ready = 1;
        @(negedge clk);
        check("stall_consume_r1", bus.req1_ready, 0);
        tick();
        @(negedge clk);
        check("stall_after_r1", bus.req1_ready, 1);
        check("stall_after_valid", bus.rsp_valid, 0);
        tick();
        bus.req1_valid = 0;
        tick();
        @(negedge clk);
        check("stall_rsp1_data", bus.rsp_data, 99);
        check("stall_rsp1_id", bus.rsp_id, 1);
        tick();

        // Reset asserted during EXEC.
        do_reset();
        bus.req0_valid = 1; bus.req0_a = 32'h11; bus.req0_b = 32'h22;
        bus.req0_sel = OP_XOR;
        @(negedge clk);
        check("rexec_accept", bus.req0_ready, 1);
        tick();
        bus.req1_valid = 1; bus.req1_a = 32'h5; bus.req1_b = 32'h6;
        #1;
        rst = 1'b1;
        #1;
        check("rexec_rsp_valid", bus.rsp_valid, 0);
        check("rexec_r0", bus.req0_ready, 0);
        check("rexec_r1", bus.req1_ready, 0);
        check("rexec_alu_a", bus.alu_a, 0);
        check("rexec_alu_b", bus.alu_b, 0);
        check("rexec_alu_sel", bus.alu_sel, 0);
        check("rexec_rsp_data", bus.rsp_data, 0);
        check("rexec_rsp_id", bus.rsp_id, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rexec_ptr_r0", bus.req0_ready, 1);
        check("rexec_ptr_r1", bus.req1_ready, 0);
        check("rexec_no_rsp", bus.rsp_valid, 0);
        tick();
        idle_inputs();
        repeat (3) tick();

        // Randomized traffic vs. transaction-level model.
        do_reset();
        m_pend = 0; m_acc = 0; m_pref = 0;
        m_id = 0; m_a = 0; m_b = 0; m_s = 0; m_d = 0;
        for (int c = 0; c < 400; c++) begin
            int  w;
            bit  rv;
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req0_a = $urandom; bus.req0_b = $urandom;
            bus.req0_sel = 4'($urandom_range(0, 15));
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req1_a = $urandom; bus.req1_b = $urandom;
            bus.req1_sel = 4'($urandom_range(0, 15));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            w = -1;
            if (!m_pend) begin
                if (bus.req0_valid && bus.req1_valid) w = m_pref;
                else if (bus.req0_valid) w = 0;
                else if (bus.req1_valid) w = 1;
            end
            rv = m_pend && (c >= m_acc + 2);
            check("rnd_ready0", bus.req0_ready, w == 0);
            check("rnd_ready1", bus.req1_ready, w == 1);
            check("rnd_rsp_valid", bus.rsp_valid, rv);
            if (rv) begin
                check("rnd_rsp_id", bus.rsp_id, m_id);
                check("rnd_rsp_data", bus.rsp_data, m_d);
            end
            if (m_pend) begin
                check("rnd_alu_a", bus.alu_a, m_a);
                check("rnd_alu_b", bus.alu_b, m_b);
                check("rnd_alu_sel", bus.alu_sel, m_s);
            end
            if (rv && bus.rsp_ready) m_pend = 0;
            if (w >= 0) begin
                m_pend = 1;
                m_acc = c;
                m_id = (w == 1);
                m_a = w ? bus.req1_a : bus.req0_a;
                m_b = w ? bus.req1_b : bus.req0_b;
                m_s = w ? bus.req1_sel : bus.req0_sel;
                m_d = alu_fn(m_a, m_b, m_s);
`ifdef ALU_ARB_FIXED_PRIO_EN
                m_pref = 0;
`else
                m_pref = 1 - w;
`endif
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
